// File: rtl/t_bram_read_arbiter_pkg.sv
// Shared types for the T BRAM read arbiter.
// T_READ_LATENCY : BRAM address-edge to data latency in cycles (HIGH_PERFORMANCE)
// req_id_t       : requester identity carried with each in-flight read
// t_tag_t        : per-read tag {valid, requester id, out-of-range error}
package t_bram_read_arbiter_pkg;

    localparam int unsigned T_READ_LATENCY = 2;

    typedef enum logic [1:0] {
        REQ_EMIN    = 2'd0,
        REQ_SEGMENT = 2'd1,
        REQ_PHI     = 2'd2
    } req_id_t;

    typedef struct packed {
        logic    v;
        req_id_t id;
        logic    err;
    } t_tag_t;

endpackage

// File: rtl/t_bram_read_arbiter_if.sv
// Bus bundle between the requesters / T BRAM and the read arbiter.
// master : requester and BRAM side (drives requests and BRAM read data)
// slave  : arbiter side (drives accepts, BRAM address, responses, busy)
// Signals: req_valid/req_addr/req_lock/req_ready per requester,
//          bram_addr/bram_data to the BRAM, resp_valid/resp_data/resp_err back
//          to the requesters, busy status.
interface t_bram_read_arbiter_if #(
    parameter int unsigned BIT_WIDTH  = 32,
    parameter int unsigned NU_VALUES  = 3,
    parameter int unsigned N_REQ      = 3,
    parameter int unsigned ADDR_WIDTH = 8
);
    logic [N_REQ-1:0]                    req_valid;
    logic [N_REQ-1:0][ADDR_WIDTH-1:0]    req_addr;
    logic [N_REQ-1:0]                    req_lock;
    logic [N_REQ-1:0]                    req_ready;
    logic [ADDR_WIDTH-1:0]               bram_addr;
    logic [NU_VALUES-1:0][BIT_WIDTH-1:0] bram_data;
    logic [N_REQ-1:0]                    resp_valid;
    logic [NU_VALUES-1:0][BIT_WIDTH-1:0] resp_data;
    logic                                resp_err;
    logic                                busy;

    modport master (
        output req_valid, req_addr, req_lock, bram_data,
        input  req_ready, bram_addr, resp_valid, resp_data, resp_err, busy
    );

    modport slave (
        input  req_valid, req_addr, req_lock, bram_data,
        output req_ready, bram_addr, resp_valid, resp_data, resp_err, busy
    );
endinterface

// File: rtl/t_bram_read_arbiter_rr_pick.sv
// Combinational round-robin picker.
// valid  : request vector
// start  : index scanned first; scan wraps modulo N
// onehot : one-hot of the first valid index found
// idx    : binary index of that requester
// any    : at least one requester is valid
module t_bram_read_arbiter_rr_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned IDX_W = 2
) (
    input  logic [N-1:0]     valid,
    input  logic [IDX_W-1:0] start,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    always_comb begin : pick
        int unsigned pos;
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = 0;
        for (int unsigned k = 0; k < N; k++) begin
            pos = (32'(start) + k) % N;
            if (!any && valid[pos]) begin
                any         = 1'b1;
                idx         = IDX_W'(pos);
                onehot[pos] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/t_bram_read_arbiter.sv
// Shares the single T BRAM read port among the emin, segment-traceback and
// phi requesters. One accept per cycle (locked hold or round-robin); each
// accepted read carries a tag down a READ_LATENCY-deep pipeline so responses
// come back in issue order to the requester that issued them.
// clk_in, rst_n_in : clock, asynchronous active-low reset
// bus (slave)      : req_valid/req_addr/req_lock in, req_ready out (comb),
//                    bram_addr out (registered), bram_data in,
//                    resp_valid/resp_data/resp_err out, busy out
module t_bram_read_arbiter
    import t_bram_read_arbiter_pkg::*;
#(
    parameter int unsigned BIT_WIDTH    = 32,
    parameter int unsigned I            = 160,
    parameter int unsigned NU_VALUES    = 3,
    parameter int unsigned N_REQ        = 3,
    parameter int unsigned READ_LATENCY = T_READ_LATENCY,
    parameter int unsigned MAX_BURST    = 8,
    parameter int unsigned ADDR_WIDTH   = $clog2(I)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    t_bram_read_arbiter_if.slave  bus
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    logic [IDX_W-1:0]               last_grant_q, last_grant_d;
    logic [CNT_W-1:0]               burst_cnt_q, burst_cnt_d;
    logic [ADDR_WIDTH-1:0]          bram_addr_q, bram_addr_d;
    t_tag_t [READ_LATENCY-1:0]      tag_q, tag_d;
    // Final stage: the tag whose BRAM data is on bram_data this cycle.
    t_tag_t                         resp_tag_q, resp_tag_d;

    logic [IDX_W-1:0]               start_idx;
    logic [N_REQ-1:0]               pick_onehot;
    logic [IDX_W-1:0]               pick_idx;
    logic                           pick_any;
    logic                           hold;
    logic [IDX_W-1:0]               grant_idx;
    logic                           grant_any;
    logic [ADDR_WIDTH-1:0]          grant_addr;
    logic                           grant_err;

    always_comb begin
        start_idx = (32'(last_grant_q) >= N_REQ - 1) ? '0 : last_grant_q + 1'b1;
    end

    t_bram_read_arbiter_rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .valid  (bus.req_valid),
        .start  (start_idx),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Once the burst counter saturates the lock stops holding; round-robin
    // then still returns the locked requester when it is the only one valid.
    always_comb begin
        hold       = bus.req_lock[last_grant_q] && bus.req_valid[last_grant_q]
                     && (burst_cnt_q < CNT_W'(MAX_BURST));
        grant_idx  = hold ? last_grant_q : pick_idx;
        grant_any  = hold || pick_any;
        grant_addr = bus.req_addr[grant_idx];
        grant_err  = (32'(grant_addr) >= I);

        bus.req_ready = '0;
        if (grant_any) begin
            bus.req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        burst_cnt_d  = burst_cnt_q;
        bram_addr_d  = bram_addr_q;
        if (grant_any) begin
            last_grant_d = grant_idx;
            bram_addr_d  = grant_addr;
            if (grant_idx != last_grant_q) begin
                burst_cnt_d = CNT_W'(1);
            end else if (burst_cnt_q < CNT_W'(MAX_BURST)) begin
                burst_cnt_d = burst_cnt_q + 1'b1;
            end
        end

        tag_d        = tag_q;
        tag_d[0].v   = grant_any;
        tag_d[0].id  = req_id_t'(grant_idx);
        tag_d[0].err = grant_any && grant_err;
        for (int unsigned k = 1; k < READ_LATENCY; k++) begin
            tag_d[k] = tag_q[k-1];
        end
        resp_tag_d = tag_q[READ_LATENCY-1];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            last_grant_q <= IDX_W'(N_REQ - 1);
            burst_cnt_q  <= '0;
            bram_addr_q  <= '0;
            tag_q        <= '0;
            resp_tag_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            burst_cnt_q  <= burst_cnt_d;
            bram_addr_q  <= bram_addr_d;
            tag_q        <= tag_d;
            resp_tag_q   <= resp_tag_d;
        end
    end

    always_comb begin
        bus.bram_addr  = bram_addr_q;
        bus.resp_valid = '0;
        if (resp_tag_q.v) begin
            bus.resp_valid[resp_tag_q.id] = 1'b1;
        end
        bus.resp_err  = resp_tag_q.v && resp_tag_q.err;
        bus.resp_data = (resp_tag_q.v && !resp_tag_q.err) ? bus.bram_data : '0;

        bus.busy = resp_tag_q.v || (|bus.req_valid);
        for (int unsigned k = 0; k < READ_LATENCY; k++) begin
            bus.busy = bus.busy || tag_q[k].v;
        end
    end
endmodule

// File: tb/tb_t_bram_read_arbiter.sv
// Directed bench for t_bram_read_arbiter. Models the T BRAM as a two-cycle
// read returning {a, a+1000, a+2000} and tracks expected responses with a
// three-cycle delay line fed from the grants the bench expects.
module tb_t_bram_read_arbiter;
    localparam int unsigned BW = 32;
    localparam int unsigned NU = 3;
    localparam int unsigned NR = 3;
    localparam int unsigned AW = 8;

    logic clk;
    logic rst_n;

    t_bram_read_arbiter_if #(
        .BIT_WIDTH  (BW),
        .NU_VALUES  (NU),
        .N_REQ      (NR),
        .ADDR_WIDTH (AW)
    ) bus ();

    t_bram_read_arbiter #(
        .BIT_WIDTH    (BW),
        .I            (160),
        .NU_VALUES    (NU),
        .N_REQ        (NR),
        .READ_LATENCY (2),
        .MAX_BURST    (8),
        .ADDR_WIDTH   (AW)
    ) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [95:0] mem_word(input logic [AW-1:0] a);
        logic [31:0] x;
        x = {24'd0, a};
        return {x, x + 32'd1000, x + 32'd2000};
    endfunction

    logic [95:0] bram_pipe;
    always @(posedge clk) begin
        bram_pipe     <= mem_word(bus.bram_addr);
        bus.bram_data <= bram_pipe;
    end

    int passed = 0;
    int total  = 0;
    int failed = 0;

    logic          ev [3];
    int            eid[3];
    logic [AW-1:0] ea [3];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_line();
        for (int k = 0; k < 3; k++) begin
            ev[k] = 1'b0; eid[k] = 0; ea[k] = '0;
        end
    endtask

    // One clock cycle: compare at the falling edge, then advance to just past
    // the next rising edge where the caller drives new inputs.
    task automatic cyc(input logic [2:0] exp_rdy, input int exp_busy);
        int idx;
        @(negedge clk);
        check("req_ready", {125'd0, bus.req_ready}, {125'd0, exp_rdy});
        check("resp_valid", {125'd0, bus.resp_valid},
              ev[2] ? {125'd0, 3'b001 << eid[2]} : 128'd0);
        if (ev[2]) begin
            check("resp_err", {127'd0, bus.resp_err}, {127'd0, (ea[2] >= 8'd160)});
            check("resp_data", {32'd0, bus.resp_data},
                  (ea[2] >= 8'd160) ? 128'd0 : {32'd0, mem_word(ea[2])});
        end
        if (exp_busy >= 0) begin
            check("busy", {127'd0, bus.busy}, 128'(exp_busy));
        end
        idx = exp_rdy[1] ? 1 : (exp_rdy[2] ? 2 : 0);
        ev[2] = ev[1]; eid[2] = eid[1]; ea[2] = ea[1];
        ev[1] = ev[0]; eid[1] = eid[0]; ea[1] = ea[0];
        ev[0] = |exp_rdy; eid[0] = idx; ea[0] = bus.req_addr[idx];
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int a;
        logic r1done;
        logic [2:0] er;

        clear_line();
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_addr  = '0;
        bus.req_lock  = '0;

        // Reset state
        @(negedge clk);
        check("rst_bram_addr", {120'd0, bus.bram_addr}, 128'd0);
        check("rst_resp_valid", {125'd0, bus.resp_valid}, 128'd0);
        check("rst_resp_err", {127'd0, bus.resp_err}, 128'd0);
        check("rst_resp_data", {32'd0, bus.resp_data}, 128'd0);
        check("rst_busy", {127'd0, bus.busy}, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // All three valid, no lock: 0,1,2,0,1,2 then in-order drain
        bus.req_valid = 3'b111;
        bus.req_addr[0] = 8'd10;
        bus.req_addr[1] = 8'd20;
        bus.req_addr[2] = 8'd30;
        for (int c = 0; c < 6; c++) begin
            cyc(3'b001 << (c % 3), 1);
        end
        bus.req_valid = '0;
        for (int c = 0; c < 4; c++) cyc(3'b000, -1);

        // Req0 alone, addr 5
        bus.req_valid = 3'b001;
        bus.req_addr[0] = 8'd5;
        cyc(3'b001, 1);
        bus.req_valid = '0;
        @(negedge clk);
        check("bram_addr_5", {120'd0, bus.bram_addr}, 128'd5);
        @(posedge clk); #1;
        ev[2] = ev[1]; eid[2] = eid[1]; ea[2] = ea[1];
        ev[1] = ev[0]; eid[1] = eid[0]; ea[1] = ea[0];
        ev[0] = 1'b0;
        for (int c = 0; c < 3; c++) cyc(3'b000, -1);

        // Out-of-range addr 160 on req2, then an in-range read
        bus.req_valid = 3'b100;
        bus.req_addr[2] = 8'd160;
        cyc(3'b100, 1);
        bus.req_addr[2] = 8'd7;
        cyc(3'b100, 1);
        bus.req_valid = '0;
        for (int c = 0; c < 3; c++) cyc(3'b000, -1);

        // Req0 locked streaming 0..159, req1 joins at cycle 3
        a = 0;
        r1done = 1'b0;
        bus.req_lock = 3'b001;
        bus.req_addr[1] = 8'd50;
        for (int c = 0; a < 160; c++) begin
            bus.req_valid = {1'b0, (c >= 3) && !r1done, 1'b1};
            bus.req_addr[0] = 8'(a);
            er = (c == 8) ? 3'b010 : 3'b001;
            cyc(er, 1);
            if (er == 3'b001) a++;
            else r1done = 1'b1;
        end
        bus.req_valid = '0;
        bus.req_lock  = '0;
        for (int c = 0; c < 3; c++) cyc(3'b000, -1);

        // Lone req1 locked, 20 back-to-back reads; busy low 3 cycles after last accept
        bus.req_lock = 3'b010;
        bus.req_valid = 3'b010;
        for (int c = 0; c < 20; c++) begin
            bus.req_addr[1] = 8'(100 + c);
            cyc(3'b010, 1);
        end
        bus.req_valid = '0;
        bus.req_lock  = '0;
        cyc(3'b000, 1);
        cyc(3'b000, 1);
        cyc(3'b000, 1);
        cyc(3'b000, 0);

        // Asynchronous reset with two reads in flight
        bus.req_valid = 3'b001;
        bus.req_addr[0] = 8'd3;
        cyc(3'b001, 1);
        bus.req_addr[0] = 8'd4;
        cyc(3'b001, 1);
        bus.req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_bram_addr", {120'd0, bus.bram_addr}, 128'd0);
        check("arst_resp_valid", {125'd0, bus.resp_valid}, 128'd0);
        check("arst_resp_err", {127'd0, bus.resp_err}, 128'd0);
        check("arst_resp_data", {32'd0, bus.resp_data}, 128'd0);
        check("arst_busy", {127'd0, bus.busy}, 128'd0);
        check("arst_req_ready", {125'd0, bus.req_ready}, 128'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        clear_line();
        for (int c = 0; c < 3; c++) cyc(3'b000, 0);
        bus.req_valid = 3'b111;
        bus.req_addr[0] = 8'd11;
        bus.req_addr[1] = 8'd12;
        bus.req_addr[2] = 8'd13;
        cyc(3'b001, 1);
        bus.req_valid = '0;
        for (int c = 0; c < 3; c++) cyc(3'b000, -1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
